// File: rtl/spi_shared_pkg.sv
// Shared SPI slave types: command encoding seen by the RAM stage, protocol FSM states, word widths.
package spi_shared_pkg;

  localparam int unsigned TX_W_DFLT = 8;
  localparam int unsigned RX_W      = TX_W_DFLT + 2;

  typedef enum logic [1:0] {
    WRITE_ADDR = 2'b00,
    WRITE_DATA = 2'b01,
    READ_ADDR  = 2'b10,
    READ_DATA  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial converter for RAM read data; MISO idles at 0 and clears when shift_en drops.
module spi_tx_serializer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         shift_en,
  output logic         miso,
  output logic         done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  sh_q;
  logic [CW-1:0] cnt_q;
  logic          miso_q;
  logic          done_q;

  // MSB goes out in the cycle right after load; cnt_q tracks bits still queued behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      miso_q <= 1'b0;
      done_q <= 1'b1;
    end else if (load) begin
      miso_q <= data[W-1];
      sh_q   <= data << 1;
      cnt_q  <= CW'(W - 1);
      done_q <= 1'b0;
    end else if (shift_en && (cnt_q != '0)) begin
      miso_q <= sh_q[W-1];
      sh_q   <= sh_q << 1;
      cnt_q  <= cnt_q - CW'(1);
    end else begin
      miso_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b1;
    end
  end

  assign miso = miso_q;
  assign done = done_q;

endmodule

// File: rtl/spi_slave_fsm.sv
// SS_n-framed SPI slave front end: deserialises {cmd,payload} words and serialises RAM read data.
// Optional select/command consistency check enabled by `define SPI_CMD_CHECK_EN.
module spi_slave_fsm
  import spi_shared_pkg::*;
#(
  parameter int unsigned TX_W        = TX_W_DFLT,
  parameter int unsigned TX_WAIT_MAX = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid,
  output logic            cmd_err
);

  localparam int unsigned CNT_W  = $clog2(RX_W + 1);
  localparam int unsigned WAIT_W = $clog2(TX_WAIT_MAX + 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [RX_W-2:0]   shift_q, shift_d;
  logic [RX_W-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rd_addr_seen_q, rd_addr_seen_d;
  logic              rd_wait_q, rd_wait_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cmd_err_q, cmd_err_d;
  logic [RX_W-1:0]   word_c;
  logic              cmd_ok_c;
  logic              tx_load_c;
  logic              tx_shift_en_c;
  logic              tx_done;

  assign word_c = {shift_q, MOSI};

`ifdef SPI_CMD_CHECK_EN
  cmd_e cmd_c;
  assign cmd_c = cmd_e'(word_c[RX_W-1 -: 2]);

  // Select bit and frame type must agree with the command field of the finished word.
  always_comb begin
    cmd_ok_c = 1'b0;
    unique case (state_q)
      ST_WRITE:     cmd_ok_c = ~cmd_c[1];
      ST_READ_ADD:  cmd_ok_c = (cmd_c == READ_ADDR);
      ST_READ_DATA: cmd_ok_c = (cmd_c == READ_DATA);
      default:      cmd_ok_c = 1'b0;
    endcase
  end
`else
  assign cmd_ok_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      rd_wait_q      <= 1'b0;
      wait_cnt_q     <= '0;
      cmd_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      rd_wait_q      <= rd_wait_d;
      wait_cnt_q     <= wait_cnt_d;
      cmd_err_q      <= cmd_err_d;
    end
  end

  // bit_cnt_q == RX_W marks a finished payload; later MOSI bits in the frame are ignored.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    rd_wait_d      = rd_wait_q;
    wait_cnt_d     = wait_cnt_q;
    cmd_err_d      = cmd_err_q;
    tx_load_c      = 1'b0;

    if (SS_n) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      shift_d    = '0;
      rd_wait_d  = 1'b0;
      wait_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_CHK_CMD;
        ST_CHK_CMD: begin
          if (!MOSI)               state_d = ST_WRITE;
          else if (rd_addr_seen_q) state_d = ST_READ_DATA;
          else                     state_d = ST_READ_ADD;
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          if (bit_cnt_q != CNT_W'(RX_W)) begin
            shift_d   = {shift_q[RX_W-3:0], MOSI};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(RX_W - 1)) begin
              if (cmd_ok_c) begin
                rx_data_d  = word_c;
                rx_valid_d = 1'b1;
                if (state_q == ST_READ_ADD) rd_addr_seen_d = 1'b1;
                if (state_q == ST_READ_DATA) begin
                  rd_addr_seen_d = 1'b0;
                  rd_wait_d      = 1'b1;
                  wait_cnt_d     = '0;
                end
              end else begin
                cmd_err_d = 1'b1;
              end
            end
          end else if (rd_wait_q) begin
            // RAM response window; a timeout abandons the read with MISO left at 0.
            if (tx_valid && tx_done) begin
              tx_load_c = 1'b1;
              rd_wait_d = 1'b0;
            end else if (wait_cnt_q == WAIT_W'(TX_WAIT_MAX - 1)) begin
              rd_wait_d = 1'b0;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tx_shift_en_c = (state_q == ST_READ_DATA) && !SS_n;

  spi_tx_serializer #(
    .W (TX_W)
  ) u_tx_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load_c),
    .data     (tx_data),
    .shift_en (tx_shift_en_c),
    .miso     (MISO),
    .done     (tx_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: directed protocol cases then randomized frames
// checked against a frame-level reference model.
module tb_spi_slave_fsm;

`ifdef SPI_CMD_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_err;

  int errors;
  int checks;

  // Reference model: what the slave should have remembered after each frame.
  bit         m_seen;
  bit         m_err;
  logic [9:0] m_rx;

  spi_slave_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_seen = 1'b0;
    m_err  = 1'b0;
    m_rx   = '0;
  endtask

  // One SS_n-framed transaction: n_bits payload bits (10 = complete); for a read-data frame the
  // RAM answers at edge 1+d after the strobe, or never (give=0) within the window.
  task automatic frame(input bit sel, input logic [9:0] word, input int n_bits, input int d,
                       input bit give, input logic [7:0] txb, input int rst_k);
    bit full;
    bit ok;
    bit is_ra;
    bit is_rd;
    int tv;
    full  = (n_bits == 10);
    is_ra = sel && !m_seen;
    is_rd = sel && m_seen;
    if (!sel)       ok = !word[9];
    else if (is_ra) ok = (word[9:8] == 2'b10);
    else            ok = (word[9:8] == 2'b11);
    ok = ok || !CHK_EN;

    SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'($urandom); tick();
    MOSI = sel; tx_valid = 1'($urandom); tick();
    for (int i = 0; i < n_bits; i++) begin
      MOSI = word[9-i];
      tx_valid = 1'($urandom);
      tick();
      chk("rx_valid_bit", 32'(rx_valid), 32'((i == 9) && ok));
    end
    tx_valid = 1'b0;

    if (full) begin
      if (ok) begin
        m_rx = word;
        if (is_ra) m_seen = 1'b1;
        if (is_rd) m_seen = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      chk("rx_data_strobe", 32'(rx_data), 32'(m_rx));
      chk("cmd_err_strobe", 32'(cmd_err), 32'(m_err));
      if (is_rd && ok) begin
        tv = give ? 1 + d : 19;
        for (int k = 1; k <= 24; k++) begin
          MOSI     = 1'($urandom);
          tx_valid = (k == tv);
          tx_data  = (k == tv) ? txb : 8'($urandom);
          if (k == rst_k) rst = 1'b1;
          tick();
          if (k == rst_k) begin
            rst = 1'b0;
            SS_n = 1'b1;
            tx_valid = 1'b0;
            model_reset();
            chk("rst_miso", 32'(MISO), 32'(0));
            chk("rst_rx_valid", 32'(rx_valid), 32'(0));
            chk("rst_rx_data", 32'(rx_data), 32'(0));
            tick();
            return;
          end
          chk("rx_valid_rd", 32'(rx_valid), 32'(0));
          chk("miso", 32'(MISO), 32'((give && k >= tv && k < tv + 8) ? txb[7-(k-tv)] : 1'b0));
        end
        tx_valid = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          MOSI = 1'($urandom);
          tx_valid = 1'($urandom);
          tick();
          chk("rx_valid_tail", 32'(rx_valid), 32'(0));
          chk("miso_tail", 32'(MISO), 32'(0));
        end
        tx_valid = 1'b0;
      end
    end

    // Partial frames present their next bit together with SS_n rising: it must not be taken.
    SS_n = 1'b1;
    MOSI = full ? 1'($urandom) : word[9-n_bits];
    tick();
    chk("rx_valid_end", 32'(rx_valid), 32'(0));
    chk("miso_end", 32'(MISO), 32'(0));
    tick();
    chk("rx_valid_idle", 32'(rx_valid), 32'(0));
    chk("rx_data_hold", 32'(rx_data), 32'(m_rx));
    chk("cmd_err_hold", 32'(cmd_err), 32'(m_err));
  endtask

  initial begin
    bit         sel;
    logic [1:0] cmd;
    logic [9:0] word;
    int         nb;

    errors = 0;
    checks = 0;
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_miso", 32'(MISO), 32'(0));
    chk("reset_rx_valid", 32'(rx_valid), 32'(0));
    chk("reset_rx_data", 32'(rx_data), 32'(0));
    chk("reset_cmd_err", 32'(cmd_err), 32'(0));
    tick();

    // Load some state, then reset after 4 payload bits of the next frame.
    frame(1'b1, 10'h2C1, 10, 1, 1'b1, 8'h00, 0);
    SS_n = 1'b0; tick();
    MOSI = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    SS_n = 1'b1;
    model_reset();
    chk("midrst_miso", 32'(MISO), 32'(0));
    chk("midrst_rx_valid", 32'(rx_valid), 32'(0));
    chk("midrst_rx_data", 32'(rx_data), 32'(0));
    tick();
    chk("midrst_no_strobe", 32'(rx_valid), 32'(0));
    tick();

    frame(1'b0, 10'h0A5, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b0, 10'h13C, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h207, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h300, 10, 1, 1'b1, 8'hC3, 0);
    frame(1'b0, 10'h155, 6, 1, 1'b1, 8'h00, 0);
    frame(1'b0, 10'h0FF, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h212, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h3A0, 10, 1, 1'b0, 8'hFF, 0);
    frame(1'b0, 10'h055, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b0, 10'h0C3, 9, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h2AB, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b1, 10'h3CD, 10, 3, 1'b1, 8'h5A, 7);
    frame(1'b0, 10'h2AA, 10, 1, 1'b1, 8'h00, 0);
    frame(1'b0, 10'h011, 10, 1, 1'b1, 8'h00, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    model_reset();
    chk("cmd_err_cleared", 32'(cmd_err), 32'(0));
    tick();

    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom);
      if (!sel)        cmd = {1'b0, 1'($urandom)};
      else if (m_seen) cmd = 2'b11;
      else             cmd = 2'b10;
      if ($urandom_range(0, 9) == 0) cmd = 2'($urandom);
      word = {cmd, 8'($urandom)};
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
      frame(sel, word, nb, int'($urandom_range(1, 6)), ($urandom_range(0, 7) != 0),
            8'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
